// File: rtl/wide_mult_axi_legup_div_core_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states and
// operand representation names.
package wide_mult_axi_legup_div_core_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam string REP_UNSIGNED = "UNSIGNED";
   localparam string REP_SIGNED   = "SIGNED";

endpackage

// File: rtl/wide_mult_axi_legup_div_core_step.sv
// One restoring radix-2 iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor magnitude if it fits.
module wide_mult_axi_legup_div_step #(
   parameter int widthb = 32
) (
   input  logic [widthb-1:0] rem_in,
   input  logic              dividend_bit,
   input  logic [widthb-1:0] divisor,
   output logic [widthb-1:0] rem_out,
   output logic              q_bit
);

   logic [widthb:0] shifted;
   logic [widthb:0] trial;

   // rem_in < divisor keeps the difference below 2^widthb, so the top bit
   // of trial is a clean borrow flag.
   always_comb begin
      shifted = {rem_in, dividend_bit};
      trial   = shifted - {1'b0, divisor};
      q_bit   = ~trial[widthb];
      rem_out = q_bit ? trial[widthb-1:0] : shifted[widthb-1:0];
   end

endmodule

// File: rtl/wide_mult_axi_legup_div_core.sv
// Multi-cycle restoring divider with valid/ready handshakes on both sides;
// one quotient bit per CALC cycle, sign correction in FIXUP.
module wide_mult_axi_legup_div_core
   import wide_mult_axi_legup_div_core_pkg::*;
#(
   parameter int    widtha         = 32,
   parameter int    widthb         = 32,
   parameter string representation = REP_UNSIGNED
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [widtha-1:0] dataa,
   input  logic [widthb-1:0] datab,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [widtha-1:0] quotient,
   output logic [widthb-1:0] remainder,
   output logic              div_by_zero
);

   localparam int CW        = $clog2(widtha + 1);
   localparam bit IS_SIGNED = (representation == REP_SIGNED);

   state_t state, state_nx;

   logic [CW-1:0]     cnt;
   logic [widtha-1:0] a_reg;
   logic [widtha-1:0] a_mag;
   logic [widthb-1:0] b_reg;
   logic [widthb-1:0] b_mag;
   logic [widthb-1:0] rem_reg;
   logic [widthb-1:0] rem_step;
   logic [widthb-1:0] a_low;
   logic              q_bit;
   logic              neg_q;
   logic              neg_r;
   logic              zero_b;
   logic              load;
   logic              step;
   logic              fix;

   always_comb begin
      a_mag = dataa;
      b_mag = datab;
      if (IS_SIGNED && dataa[widtha-1]) a_mag = -dataa;
      if (IS_SIGNED && datab[widthb-1]) b_mag = -datab;
   end

   wide_mult_axi_legup_div_step #(
      .widthb(widthb)
   ) u_step (
      .rem_in       (rem_reg),
      .dividend_bit (a_reg[widtha-1]),
      .divisor      (b_reg),
      .rem_out      (rem_step),
      .q_bit        (q_bit)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      fix       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load     = 1'b1;
               state_nx = CALC;
            end
         end
         CALC: begin
            step = 1'b1;
            if (cnt == CW'(widtha - 1)) state_nx = FIXUP;
         end
         FIXUP: begin
            fix      = 1'b1;
            state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // a_reg starts as the dividend magnitude and fills with quotient bits
   // from the bottom as dividend bits leave from the top.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt         <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         rem_reg     <= '0;
         a_low       <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         zero_b      <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         if (load) begin
            cnt     <= '0;
            a_reg   <= a_mag;
            b_reg   <= b_mag;
            rem_reg <= '0;
            a_low   <= dataa[widthb-1:0];
            neg_q   <= IS_SIGNED & (dataa[widtha-1] ^ datab[widthb-1]);
            neg_r   <= IS_SIGNED & dataa[widtha-1];
            zero_b  <= (datab == '0);
         end
         if (step) begin
            cnt     <= cnt + 1'b1;
            a_reg   <= {a_reg[widtha-2:0], q_bit};
            rem_reg <= rem_step;
         end
         if (fix) begin
            if (zero_b) begin
               quotient    <= '1;
               remainder   <= a_low;
               div_by_zero <= 1'b1;
            end else begin
               quotient    <= neg_q ? -a_reg : a_reg;
               remainder   <= neg_r ? -rem_reg : rem_reg;
               div_by_zero <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_wide_mult_axi_legup_div_core.sv
// Directed self-checking bench: a 32/32 unsigned and an 8/8 signed divider
// driven from one linear stimulus sequence.
module tb_wide_mult_axi_legup_div_core;

   logic        clk;
   logic        reset_n;

   logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_dbz;
   logic [31:0] u_dataa, u_datab, u_q, u_r;

   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_dbz;
   logic [7:0]  s_dataa, s_datab, s_q, s_r;

   int checks = 0;
   int errors = 0;

   wide_mult_axi_legup_div_core #(
      .widtha(32),
      .widthb(32),
      .representation("UNSIGNED")
   ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(u_in_valid), .in_ready(u_in_ready),
      .dataa(u_dataa), .datab(u_datab),
      .out_valid(u_out_valid), .out_ready(u_out_ready),
      .quotient(u_q), .remainder(u_r), .div_by_zero(u_dbz)
   );

   wide_mult_axi_legup_div_core #(
      .widtha(8),
      .widthb(8),
      .representation("SIGNED")
   ) s_dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready),
      .dataa(s_dataa), .datab(s_datab),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .quotient(s_q), .remainder(s_r), .div_by_zero(s_dbz)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic u_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic ez, input string tag);
      int  lat;
      bit  found;
      @(negedge clk);
      check({tag, " in_ready"}, 64'(u_in_ready), 64'd1);
      u_dataa = a; u_datab = b; u_in_valid = 1'b1;
      @(posedge clk);
      lat = 0; found = 0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge clk);
         u_in_valid = 1'b0;
         u_dataa = ~a; u_datab = ~b;
         if (u_out_valid) found = 1;
         else begin
            @(posedge clk);
            lat++;
         end
      end
      check({tag, " latency"}, 64'(lat + 1), 64'd34);
      check({tag, " quotient"}, 64'(u_q), 64'(eq));
      check({tag, " remainder"}, 64'(u_r), 64'(er));
      check({tag, " div_by_zero"}, 64'(u_dbz), 64'(ez));
   endtask

   task automatic u_consume(input string tag);
      u_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      u_out_ready = 1'b0;
      check({tag, " in_ready after consume"}, 64'({u_in_ready, u_out_valid}), 64'b10);
   endtask

   task automatic s_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic ez, input string tag);
      int  lat;
      bit  found;
      @(negedge clk);
      s_dataa = a; s_datab = b; s_in_valid = 1'b1;
      @(posedge clk);
      lat = 0; found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         s_in_valid = 1'b0;
         s_dataa = ~a; s_datab = ~b;
         if (s_out_valid) found = 1;
         else begin
            @(posedge clk);
            lat++;
         end
      end
      check({tag, " latency"}, 64'(lat + 1), 64'd10);
      check({tag, " quotient"}, 64'(s_q), 64'(eq));
      check({tag, " remainder"}, 64'(s_r), 64'(er));
      check({tag, " div_by_zero"}, 64'(s_dbz), 64'(ez));
      s_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_out_ready = 1'b0;
      check({tag, " in_ready after consume"}, 64'(s_in_ready), 64'd1);
   endtask

   initial begin
      int seen;
      reset_n = 1'b0;
      u_in_valid = 1'b0; u_out_ready = 1'b0; u_dataa = '0; u_datab = '0;
      s_in_valid = 1'b0; s_out_ready = 1'b0; s_dataa = '0; s_datab = '0;

      repeat (2) @(negedge clk);
      check("reset u outputs", 64'({u_out_valid, u_dbz, u_q, u_r}), 64'd0);
      check("reset s outputs", 64'({s_out_valid, s_dbz, s_q, s_r}), 64'd0);
      reset_n = 1'b1;
      #1;
      check("reset u in_ready", 64'(u_in_ready), 64'd1);

      u_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "u 100/7");
      u_consume("u 100/7");
      u_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, "u max/1");
      u_consume("u max/1");
      u_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, "u 5/0");
      u_consume("u 5/0");
      u_op(32'd7, 32'd100, 32'd0, 32'd7, 1'b0, "u 7/100");
      u_consume("u 7/100");
      u_op(32'h1234_5678, 32'h1000, 32'h0001_2345, 32'h678, 1'b0, "u hex");
      u_consume("u hex");
      u_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, "u max/max");
      u_consume("u max/max");

      // Backpressure: result held, in_valid pulses ignored while in DONE.
      u_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "u bp");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         u_in_valid = i[0];
         u_dataa = 32'd999 + 32'(i); u_datab = 32'd3;
         check("bp hold q/r/valid/in_ready",
               64'({u_q[15:0], u_r[15:0], u_out_valid, u_in_ready, u_dbz}),
               64'({16'd14, 16'd2, 1'b1, 1'b0, 1'b0}));
      end
      @(negedge clk);
      u_in_valid = 1'b0;
      check("bp still valid", 64'({u_out_valid, u_q}), 64'({1'b1, 32'd14}));
      u_consume("u bp");

      s_op(8'hF9, 8'd2,  8'hFD, 8'hFF, 1'b0, "s -7/2");
      s_op(8'd7,  8'hFE, 8'hFD, 8'h01, 1'b0, "s 7/-2");
      s_op(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, "s -128/-1");
      s_op(8'd5,  8'h00, 8'hFF, 8'h05, 1'b1, "s 5/0");
      s_op(8'h80, 8'h00, 8'hFF, 8'h80, 1'b1, "s -128/0");
      s_op(8'h9C, 8'd7,  8'hF2, 8'hFE, 1'b0, "s -100/7");
      s_op(8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, "s 127/-128");

      // Reset ten cycles into CALC; outputs still hold the 100/7 result.
      @(negedge clk);
      u_dataa = 32'd100; u_datab = 32'd7; u_in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      u_in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midcalc reset outputs", 64'({u_out_valid, u_dbz, u_q, u_r}), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("midcalc in_ready", 64'(u_in_ready), 64'd1);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (u_out_valid) seen++;
      end
      check("no stale result", 64'(seen), 64'd0);
      u_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "u after reset");
      u_consume("u after reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
